// File: rtl/interface_axis_slave.sv
`default_nettype none
// =============================================================================
// interface_axis_slave : AXI-Stream slave writing one bounded packet to a buffer
// Rev 1.0
// =============================================================================
module interface_axis_slave #(
  parameter int ADDR_BIT = 16,
  parameter int DATA_BIT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                recv_enable,
  input  logic [ADDR_BIT-1:0] addr_start,
  input  logic [ADDR_BIT-1:0] addr_end,
  input  logic                s_axis_tvalid,
  input  logic [DATA_BIT-1:0] s_axis_tdata,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic                write_en,
  output logic [ADDR_BIT-1:0] write_addr,
  output logic [DATA_BIT-1:0] write_data,
  output logic                recv_done,
  output logic                err_short,
  output logic                err_long,
  output logic [ADDR_BIT-1:0] beat_count
);

  localparam logic [ADDR_BIT-1:0] ADDR_ONE = {{(ADDR_BIT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_BIT-1:0] base_addr;
  logic [ADDR_BIT-1:0] len;
  logic [ADDR_BIT-1:0] len_req;
  logic                handshake;
  logic                at_last;

  assign len_req       = addr_end - addr_start;
  assign s_axis_tready = (state == RECV) || (state == DRAIN);
  assign recv_done     = (state == DONE);
  assign handshake     = s_axis_tvalid & s_axis_tready;
  // Only meaningful in RECV, where len is guaranteed non-zero.
  assign at_last       = (beat_count == (len - ADDR_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (recv_enable) begin
          state_next = (len_req != '0) ? RECV : DONE;
        end
      end
      RECV: begin
        if (handshake) begin
          if (at_last && !s_axis_tlast) begin
            state_next = DRAIN;
          end else if (at_last || s_axis_tlast) begin
            state_next = DONE;
          end
        end
      end
      DRAIN: begin
        if (handshake && s_axis_tlast) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_addr  <= '0;
      len        <= '0;
      beat_count <= '0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      write_en <= 1'b0;
      if ((state == IDLE) && recv_enable) begin
        base_addr  <= addr_start;
        len        <= len_req;
        beat_count <= '0;
        err_short  <= 1'b0;
        err_long   <= 1'b0;
      end
      if ((state == RECV) && handshake) begin
        write_en   <= 1'b1;
        write_addr <= base_addr + beat_count;
        write_data <= s_axis_tdata;
        beat_count <= beat_count + ADDR_ONE;
        if (s_axis_tlast && !at_last) begin
          err_short <= 1'b1;
        end
        if (!s_axis_tlast && at_last) begin
          err_long <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interface_axis_slave.sv
`default_nettype none
// tb_interface_axis_slave : directed stimulus, packet-level model and per-cycle compare
`timescale 1ns/1ps
module tb_interface_axis_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        recv_enable = 1'b0;
  logic [15:0] addr_start = '0;
  logic [15:0] addr_end = '0;
  logic        s_axis_tvalid = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic        write_en;
  logic [15:0] write_addr;
  logic [63:0] write_data;
  logic        recv_done;
  logic        err_short;
  logic        err_long;
  logic [15:0] beat_count;

  interface_axis_slave #(.ADDR_BIT(16), .DATA_BIT(64)) dut (
    .clk(clk), .rst_n(rst_n), .recv_enable(recv_enable),
    .addr_start(addr_start), .addr_end(addr_end),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .recv_done(recv_done), .err_short(err_short), .err_long(err_long),
    .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: tracks busy/discarding, accepted count and the expected
  // observable outputs for the cycle following each edge.
  logic        m_busy = 1'b0, m_drop = 1'b0, m_es = 1'b0, m_el = 1'b0;
  logic [15:0] m_base = '0, m_len = '0, m_cnt = '0;
  logic        exp_we = 1'b0, exp_done = 1'b0;
  logic [15:0] exp_addr = '0;
  logic [63:0] exp_data = '0;
  logic        done_prev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_drop = 0; m_es = 0; m_el = 0; m_base = 0; m_len = 0; m_cnt = 0;
      exp_we = 0; exp_done = 0; exp_addr = 0; exp_data = 0;
    end else begin
      done_prev = exp_done;
      exp_we = 0;
      exp_done = 0;
      if (m_busy) begin
        if (s_axis_tvalid) begin
          if (!m_drop) begin
            exp_we = 1; exp_addr = m_base + m_cnt; exp_data = s_axis_tdata;
            m_cnt = m_cnt + 16'd1;
            if (s_axis_tlast) begin
              m_es = (m_cnt < m_len); m_busy = 0; exp_done = 1;
            end else if (m_cnt == m_len) begin
              m_el = 1; m_drop = 1;
            end
          end else if (s_axis_tlast) begin
            m_busy = 0; exp_done = 1;
          end
        end
      end else if (!done_prev && recv_enable) begin
        m_base = addr_start; m_len = addr_end - addr_start;
        m_cnt = 0; m_es = 0; m_el = 0; m_drop = 0;
        if (m_len == 16'd0) exp_done = 1;
        else m_busy = 1;
      end
    end
  end

  // Per-cycle comparison plus a log of what the DUT actually did.
  logic [15:0] wr_addr_log[$];
  logic [63:0] wr_data_log[$];
  int          done_cnt = 0, done_wr = 0, tready_seen = 0;

  always @(negedge clk) begin
    check("tready", s_axis_tready, m_busy);
    check("write_en", write_en, exp_we);
    if (exp_we) begin
      check("write_addr", write_addr, exp_addr);
      check("write_data", write_data, exp_data);
    end
    check("recv_done", recv_done, exp_done);
    check("err_short", err_short, m_es);
    check("err_long", err_long, m_el);
    check("beat_count", beat_count, m_cnt);
    if (write_en) begin
      wr_addr_log.push_back(write_addr);
      wr_data_log.push_back(write_data);
    end
    if (recv_done) done_cnt++;
    if (recv_done && write_en) done_wr++;
    if (s_axis_tready) tready_seen++;
  end

  task automatic clear_log();
    wr_addr_log.delete(); wr_data_log.delete();
    done_cnt = 0; done_wr = 0; tready_seen = 0;
  endtask

  function automatic logic [63:0] bd(input int t, input int i);
    return {32'hDA7A_0000 | 32'(t), 32'(i) * 32'h0101_0101 + 32'h11};
  endfunction

  task automatic start(input logic [15:0] s, input logic [15:0] e);
    @(posedge clk); #1;
    addr_start = s; addr_end = e; recv_enable = 1'b1;
    @(posedge clk); #1;
    recv_enable = 1'b0;
    addr_start = 16'h5555; addr_end = 16'hAAAA;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, input int gap);
    logic hs;
    logic ok;
    for (int g = 0; g < gap; g++) begin
      s_axis_tvalid = 1'b0; s_axis_tdata = '1; s_axis_tlast = 1'b1;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = last;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk); #1;
      ok = hs;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: got no tready expected tready within 20 cycles");
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", s_axis_tready, 0);
    check("rst_write_en", write_en, 0);
    check("rst_recv_done", recv_done, 0);
    check("rst_errs", {err_short, err_long}, 0);
    check("rst_beat_count", beat_count, 0);
    check("rst_write_addr", write_addr, 0);
    check("rst_write_data", write_data, 0);
    rst_n = 1'b1;

    // Basic 4-beat transfer; a stray recv_enable mid-transfer must be ignored.
    clear_log();
    start(16'h0010, 16'h0014);
    recv_enable = 1'b1;
    send_beat(bd(1, 0), 0, 0);
    send_beat(bd(1, 1), 0, 0);
    recv_enable = 1'b0;
    send_beat(bd(1, 2), 0, 0);
    send_beat(bd(1, 3), 1, 0);
    idle(4);
    check("t1_writes", wr_addr_log.size(), 4);
    if (wr_addr_log.size() == 4) begin
      check("t1_first_addr", wr_addr_log[0], 16'h0010);
      check("t1_last_addr", wr_addr_log[3], 16'h0013);
    end
    check("t1_done", done_cnt, 1);
    check("t1_done_with_write", done_wr, 1);
    check("t1_beat_count", beat_count, 4);
    check("t1_errs", {err_short, err_long}, 0);

    // Same transfer with tvalid toggling.
    clear_log();
    start(16'h0010, 16'h0014);
    for (int i = 0; i < 4; i++) send_beat(bd(2, i), (i == 3), 1);
    idle(4);
    check("t2_writes", wr_addr_log.size(), 4);
    if (wr_addr_log.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check("t2_addr", wr_addr_log[i], 16'h0010 + 16'(i));
        check("t2_data", wr_data_log[i], bd(2, i));
      end
    check("t2_done", done_cnt, 1);

    // Short packet.
    clear_log();
    start(16'h0000, 16'h0004);
    send_beat(bd(3, 0), 0, 0);
    send_beat(bd(3, 1), 1, 0);
    idle(4);
    check("t3_writes", wr_addr_log.size(), 2);
    check("t3_err_short", err_short, 1);
    check("t3_err_long", err_long, 0);
    check("t3_beat_count", beat_count, 2);
    check("t3_done", done_cnt, 1);

    // Long packet: extra beats drained.
    clear_log();
    start(16'h0000, 16'h0002);
    for (int i = 0; i < 5; i++) send_beat(bd(4, i), (i == 4), 0);
    idle(4);
    check("t4_writes", wr_addr_log.size(), 2);
    check("t4_err_long", err_long, 1);
    check("t4_err_short", err_short, 0);
    check("t4_beat_count", beat_count, 2);
    check("t4_done", done_cnt, 1);
    check("t4_done_no_write", done_wr, 0);

    // Address wrap.
    clear_log();
    start(16'hFFFE, 16'h0001);
    for (int i = 0; i < 3; i++) send_beat(bd(5, i), (i == 2), 0);
    idle(4);
    check("t5_writes", wr_addr_log.size(), 3);
    if (wr_addr_log.size() == 3) begin
      check("t5_addr0", wr_addr_log[0], 16'hFFFE);
      check("t5_addr1", wr_addr_log[1], 16'hFFFF);
      check("t5_addr2", wr_addr_log[2], 16'h0000);
    end
    check("t5_errs", {err_short, err_long}, 0);

    // Zero-length transfer.
    clear_log();
    start(16'h0007, 16'h0007);
    idle(4);
    check("t6_done", done_cnt, 1);
    check("t6_tready_seen", tready_seen, 0);
    check("t6_writes", wr_addr_log.size(), 0);

    // Reset mid-transfer, then a clean transfer.
    start(16'h0000, 16'h0004);
    send_beat(bd(7, 0), 0, 0);
    send_beat(bd(7, 1), 0, 0);
    clear_log();
    #2 rst_n = 1'b0;
    #1;
    check("r_write_en", write_en, 0);
    check("r_tready", s_axis_tready, 0);
    check("r_beat_count", beat_count, 0);
    check("r_write_addr", write_addr, 0);
    check("r_write_data", write_data, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check("r_no_writes", wr_addr_log.size(), 0);
    clear_log();
    start(16'h0020, 16'h0024);
    for (int i = 0; i < 4; i++) send_beat(bd(8, i), (i == 3), 0);
    idle(4);
    check("t8_writes", wr_addr_log.size(), 4);
    if (wr_addr_log.size() == 4) check("t8_first_addr", wr_addr_log[0], 16'h0020);
    check("t8_done", done_cnt, 1);
    check("t8_beat_count", beat_count, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
